// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 timing constants, RGB222 types and helpers used by the
// scanout and the object renderer.
package vga_timing_pkg;

    localparam int H_VISIBLE_C = 800;
    localparam int H_FP_C      = 40;
    localparam int H_SYNC_C    = 128;
    localparam int H_BP_C      = 88;
    localparam int H_TOTAL_C   = H_VISIBLE_C + H_FP_C + H_SYNC_C + H_BP_C;

    localparam int V_VISIBLE_C = 600;
    localparam int V_FP_C      = 1;
    localparam int V_SYNC_C    = 4;
    localparam int V_BP_C      = 23;
    localparam int V_TOTAL_C   = V_VISIBLE_C + V_FP_C + V_SYNC_C + V_BP_C;

    // frame_tick fires on the first blanking pixel after the last visible line
    localparam int FRAME_TICK_H_C = H_VISIBLE_C;
    localparam int FRAME_TICK_V_C = V_VISIBLE_C;

    localparam int RGB_W = 6;
    typedef logic [RGB_W-1:0] rgb222_t;
    localparam rgb222_t RGB_BLANK = 6'b000000;

    typedef logic [10:0] cntr_h_t;
    typedef logic [9:0]  cntr_v_t;
    typedef logic [15:0] frame_cnt_t;

    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
    } timing_flags_t;

    function automatic logic in_window(input int pos, input int lo, input int len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Pixel/timing bus between the scanout (master) and the object renderer (slave).
interface vga_scanout_if;
    import vga_timing_pkg::*;

    rgb222_t    pixel_in;
    cntr_h_t    cntr_h;
    cntr_v_t    cntr_v;
    logic       frame_tick;
    frame_cnt_t frame_cnt;
    rgb222_t    vga_rgb;
    logic       hsync;
    logic       vsync;

    modport master (
        input  pixel_in,
        output cntr_h, cntr_v, frame_tick, frame_cnt, vga_rgb, hsync, vsync
    );

    modport slave (
        output pixel_in,
        input  cntr_h, cntr_v, frame_tick, frame_cnt, vga_rgb, hsync, vsync
    );

endinterface

// File: rtl/delay_line.sv
// Parameterised shift register with synchronous active-low clear; DEPTH=0
// degenerates to a plain wire.
module delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst_s;
        assign unused_clk_rst_s = clk ^ rst_n;
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        // Stage 0 loads the input, each later stage takes its predecessor.
        always_comb begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        // Shift register state.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= {WIDTH{1'b0}};
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA raster counters, frame counter and registered RGB/sync outputs, with the
// timing flags delayed to line up with the renderer's pixel pipeline.
module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE     = H_VISIBLE_C,
    parameter int   H_FP          = H_FP_C,
    parameter int   H_SYNC        = H_SYNC_C,
    parameter int   H_BP          = H_BP_C,
    parameter int   V_VISIBLE     = V_VISIBLE_C,
    parameter int   V_FP          = V_FP_C,
    parameter int   V_SYNC        = V_SYNC_C,
    parameter int   V_BP          = V_BP_C,
    parameter logic SYNC_POL      = 1'b1,
    parameter int   PIXEL_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_scanout_if.master bus
);

    localparam int      H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int      V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam cntr_h_t H_LAST  = cntr_h_t'(H_TOTAL - 1);
    localparam cntr_v_t V_LAST  = cntr_v_t'(V_TOTAL - 1);
    localparam cntr_h_t TICK_H  = cntr_h_t'(H_VISIBLE);
    localparam cntr_v_t TICK_V  = cntr_v_t'(V_VISIBLE);

    cntr_h_t       cntr_h_q, cntr_h_d;
    cntr_v_t       cntr_v_q, cntr_v_d;
    frame_cnt_t    frame_cnt_q, frame_cnt_d;
    rgb222_t       vga_rgb_q, vga_rgb_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_tick_s;
    timing_flags_t flags_s, flags_dly_s;

    // Raster advance; ">=" also pulls any out-of-range value back to 0.
    always_comb begin
        cntr_h_d = cntr_h_q + 11'd1;
        cntr_v_d = cntr_v_q;
        if (cntr_h_q >= H_LAST) begin
            cntr_h_d = 11'd0;
            if (cntr_v_q >= V_LAST) begin
                cntr_v_d = 10'd0;
            end else begin
                cntr_v_d = cntr_v_q + 10'd1;
            end
        end else begin
            cntr_v_d = cntr_v_q;
        end
    end

    // Timing flags and frame counter next state, decoded from the live counters.
    always_comb begin
        frame_tick_s     = (cntr_h_q == TICK_H) && (cntr_v_q == TICK_V);
        flags_s.visible  = in_window(int'(cntr_h_q), 0, H_VISIBLE)
                        && in_window(int'(cntr_v_q), 0, V_VISIBLE);
        flags_s.hsync    = in_window(int'(cntr_h_q), H_VISIBLE + H_FP, H_SYNC);
        flags_s.vsync    = in_window(int'(cntr_v_q), V_VISIBLE + V_FP, V_SYNC);
        if (frame_tick_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    delay_line #(
        .WIDTH ($bits(timing_flags_t)),
        .DEPTH (PIXEL_LATENCY)
    ) u_flag_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (flags_s),
        .dout  (flags_dly_s)
    );

    // Output stage: pixel_in only reaches the DAC inside the delayed visible window.
    always_comb begin
        if (flags_dly_s.visible) begin
            vga_rgb_d = bus.pixel_in;
        end else begin
            vga_rgb_d = RGB_BLANK;
        end
        hsync_d = flags_dly_s.hsync ? SYNC_POL : ~SYNC_POL;
        vsync_d = flags_dly_s.vsync ? SYNC_POL : ~SYNC_POL;
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cntr_h_q    <= 11'd0;
            cntr_v_q    <= 10'd0;
            frame_cnt_q <= 16'd0;
            vga_rgb_q   <= RGB_BLANK;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
        end else begin
            cntr_h_q    <= cntr_h_d;
            cntr_v_q    <= cntr_v_d;
            frame_cnt_q <= frame_cnt_d;
            vga_rgb_q   <= vga_rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign bus.cntr_h     = cntr_h_q;
    assign bus.cntr_v     = cntr_v_q;
    assign bus.frame_tick = frame_tick_s;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.vga_rgb    = vga_rgb_q;
    assign bus.hsync      = hsync_q;
    assign bus.vsync      = vsync_q;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_VISIBLE, 800, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal porches and sync width in clocks.
REQ-003 Parameter V_VISIBLE, 600, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porches and sync width in lines.
REQ-005 Parameter SYNC_POL, 1, asserted level of hsync/vsync.
REQ-006 Parameter PIXEL_LATENCY, 1, clocks from counter value to matching pixel_in; legal range 0..4.
REQ-007 clk  in  1  pixel clock, 40 MHz; single clock domain.
REQ-008 rst_n  in  1  synchronous reset, active-low.
REQ-009 pixel_in  in  6  RGB222 pixel from object renderer, {R[5:4],G[3:2],B[1:0]}.
REQ-010 cntr_h  out  11  current horizontal position, 0..1055.
REQ-011 cntr_v  out  10  current vertical position, 0..627.
REQ-012 frame_tick  out  1  one-clock pulse at cntr_h==800 and cntr_v==600.
REQ-013 frame_cnt  out  16  frames completed since reset, wraps modulo 2^16.
REQ-014 vga_rgb  out  6  registered RGB to DAC, zero outside visible area.
REQ-015 hsync / vsync  out  1 each  registered sync outputs.

Function
REQ-016 H_TOTAL = sum of H params (1056); V_TOTAL = sum of V params (628); both derived, never free parameters.
REQ-017 cntr_h increments by 1 every clock; at H_TOTAL-1 it wraps to 0 next clock.
REQ-018 cntr_v increments only on the clock where cntr_h wraps; at V_TOTAL-1 with cntr_h wrap, both go to 0.
REQ-019 visible = (cntr_h < H_VISIBLE) and (cntr_v < V_VISIBLE); combinational, internal.
REQ-020 hsync_raw asserted for cntr_h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC) = [840,968).
REQ-021 vsync_raw asserted for cntr_v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC) = [601,605), for whole lines.
REQ-022 frame_tick combinational from counters; high exactly one clock per frame.
REQ-023 frame_cnt increments on the clock after frame_tick; 0xFFFF wraps to 0x0000.
REQ-024 visible, hsync_raw, vsync_raw are delayed PIXEL_LATENCY clocks by a shift register; PIXEL_LATENCY=0 means no delay stage.
REQ-025 vga_rgb registers pixel_in when delayed visible=1, else 6'b000000.
REQ-026 hsync/vsync register delayed raw syncs, driven as SYNC_POL when asserted, ~SYNC_POL otherwise.
REQ-027 Total latency, counter value -> vga_rgb/hsync/vsync: PIXEL_LATENCY+1 clocks, identical for all three.
REQ-028 pixel_in is ignored (no effect on outputs) whenever delayed visible=0.
REQ-029 No counter value outside 0..H_TOTAL-1 / 0..V_TOTAL-1 is ever produced.

Reset
REQ-030 While rst_n=0 at a clk edge: cntr_h=0, cntr_v=0, frame_cnt=0, all delay stages cleared to not-visible/not-sync.
REQ-031 During and one clock after reset: vga_rgb=0, hsync=vsync=~SYNC_POL, frame_tick=0.
REQ-032 Reset mid-frame abandons the frame; first clock after release shows cntr_h=0, cntr_v=0; frame_cnt not incremented.
REQ-033 After release, first visible pixel reaches vga_rgb PIXEL_LATENCY+1 clocks later.

Structure
REQ-034 Timing constants (800x600@60 values, H_TOTAL, V_TOTAL, frame_tick coordinates) live in shared vga_timing_pkg, also used by the object renderer.
REQ-035 RGB222 width (6) and blank colour constant live in the same package.
REQ-036 One sub-module: delay_line (parameterised width and depth, sync active-low reset), carrying {visible,hsync_raw,vsync_raw}.
REQ-037 Counters and output registers stay in vga_scanout; no other sub-modules.

Verification
REQ-038 Reset then free-run 2 frames -> cntr_h period 1056 clocks, cntr_v period 628 lines, 663168 clocks per frame.
REQ-039 Check sync windows -> hsync=1 for exactly 128 clocks starting cntr_h=840 (+L+1 delay); vsync=1 for 4 lines starting cntr_v=601.
REQ-040 pixel_in=6'b110011 held constant, PIXEL_LATENCY=1 -> vga_rgb=6'b110011 only for 800x600 visible pixels, delayed 2 clocks; 0 elsewhere.
REQ-041 Count frame_tick over 3 frames -> exactly 3 pulses, each at (800,600); frame_cnt 0->1->2->3.
REQ-042 Assert rst_n=0 for 1 clock at (400,300) -> next clock (0,0), vga_rgb=0, syncs inactive, frame_cnt unchanged (0 after first-frame reset).
REQ-043 Run PIXEL_LATENCY=0 and 3 -> alignment of vga_rgb, hsync, vsync to counters is L+1 clocks in both builds.
